mac_tx_framer: RTL and testbench

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

---
 rtl/mac_tx_framer.sv | 241 ++++++++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_framer.sv
// mac_tx_framer
//   Wraps an AXI-Stream payload (32-bit words, lane 0 first on the wire) into
//   an XGMII transmit stream. It emits the start and preamble words, then the
//   payload, zero padding up to MIN_WORDS, an optional FCS, and the terminate
//   word. A gap of IFG_WORDS idle words always follows.
//   An underrun or an illegal tkeep produces an error word. The rest of that
//   frame is then discarded.
//
//   Optional feature: define MAC_TX_FCS_EN to append a CRC-32 FCS word.
//   Without it there is no FCS state and no CRC logic.
//
// Ports
//   clk            in   single clock
//   reset          in   asynchronous active-high reset
//   s_axis_tdata   in   32  payload word, [7:0] is first byte on the wire
//   s_axis_tkeep   in   4   byte enables, only 4'hF is legal
//   s_axis_tvalid  in   1   upstream word valid
//   s_axis_tlast   in   1   last word of frame
//   s_axis_trdy    out  1   framer ready (decoded from state)
//   xgmii_txd      out  32  XGMII data, lane 0 is [7:0] (registered)
//   xgmii_txc      out  4   XGMII control, one bit per lane (registered)
//   tx_frame_done  out  1   pulse with a good terminate word (registered)
//   tx_err         out  1   pulse with an error word (registered)
module mac_tx_framer #(
    parameter int IFG_WORDS = 3,
    parameter int MIN_WORDS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_trdy,
    output logic [31:0] xgmii_txd,
    output logic [3:0]  xgmii_txc,
    output logic        tx_frame_done,
    output logic        tx_err
);

    localparam int CNT_W = $clog2(MIN_WORDS + 1);
    localparam int IFG_W = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_WORDS);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_WORDS - 1);

    localparam logic [31:0] IDLE_WORD  = 32'h07070707;
    localparam logic [31:0] START_WORD = 32'h555555FB;
    localparam logic [31:0] PRE_WORD   = 32'hD5555555;
    localparam logic [31:0] TERM_WORD  = 32'h070707FD;
    localparam logic [31:0] ERR_WORD   = 32'hFEFEFEFE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_PRE,
        ST_DATA,
        ST_PAD,
`ifdef MAC_TX_FCS_EN
        ST_FCS,
`endif
        ST_TERM,
        ST_DROP,
        ST_IFG
    } state_t;

    // State entered once the payload (data plus padding) is complete.
`ifdef MAC_TX_FCS_EN
    localparam state_t ST_TAIL = ST_FCS;
`else
    localparam state_t ST_TAIL = ST_TERM;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IFG_W-1:0] r_ifg_cnt;
    logic [31:0]      r_txd;
    logic [3:0]       r_txc;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [IFG_W-1:0] w_ifg_nxt;
    logic [31:0]      w_txd_nxt;
    logic [3:0]       w_txc_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    // Word counter saturates at MIN_WORDS; only "below minimum" matters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= MIN_CNT) ? MIN_CNT : cnt + 1'b1;
    endfunction

`ifdef MAC_TX_FCS_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    // Reflected CRC-32 (0x04C11DB7 -> 0xEDB88320) over one word.
    // Bits are taken LSB first, starting with lane 0, in wire order.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                c = c >> 1;
        end
        return c;
    endfunction
`endif

    assign w_cnt_inc = sat_inc(r_cnt);

    // Ready only where a word can be consumed: preamble/data (to transmit)
    // and drop (to discard).
    assign s_axis_trdy = (r_state == ST_PRE) || (r_state == ST_DATA) ||
                         (r_state == ST_DROP);

    // Outputs are computed here and registered, so each state's word
    // appears in the cycle after the decision is made.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ifg_nxt   = r_ifg_cnt;
        w_txd_nxt   = IDLE_WORD;
        w_txc_nxt   = 4'hF;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef MAC_TX_FCS_EN
        w_crc_nxt   = r_crc;
`endif
        case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    w_state_nxt = ST_START;
                    w_txd_nxt   = START_WORD;
                    w_txc_nxt   = 4'b0001;
                end
            end
            ST_START: begin
                w_state_nxt = ST_PRE;
                w_txd_nxt   = PRE_WORD;
                w_txc_nxt   = 4'h0;
                w_cnt_nxt   = '0;
`ifdef MAC_TX_FCS_EN
                w_crc_nxt   = 32'hFFFFFFFF;
`endif
            end
            ST_PRE, ST_DATA: begin
                if (!s_axis_tvalid) begin
                    // Underrun: tvalid is low, so tlast carries no meaning.
                    w_txd_nxt   = ERR_WORD;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DROP;
                end else if (s_axis_tkeep != 4'hF) begin
                    w_txd_nxt   = ERR_WORD;
                    w_err_nxt   = 1'b1;
                    w_ifg_nxt   = '0;
                    w_state_nxt = s_axis_tlast ? ST_IFG : ST_DROP;
                end else begin
                    w_txd_nxt = s_axis_tdata;
                    w_txc_nxt = 4'h0;
                    w_cnt_nxt = w_cnt_inc;
`ifdef MAC_TX_FCS_EN
                    w_crc_nxt = crc32_word(r_crc, s_axis_tdata);
`endif
                    if (!s_axis_tlast)           w_state_nxt = ST_DATA;
                    else if (w_cnt_inc < MIN_CNT) w_state_nxt = ST_PAD;
                    else                          w_state_nxt = ST_TAIL;
                end
            end
            ST_PAD: begin
                w_txd_nxt = 32'h0;
                w_txc_nxt = 4'h0;
                w_cnt_nxt = w_cnt_inc;
`ifdef MAC_TX_FCS_EN
                w_crc_nxt = crc32_word(r_crc, 32'h0);
`endif
                if (w_cnt_inc >= MIN_CNT) w_state_nxt = ST_TAIL;
            end
`ifdef MAC_TX_FCS_EN
            ST_FCS: begin
                w_txd_nxt   = ~r_crc;
                w_txc_nxt   = 4'h0;
                w_state_nxt = ST_TERM;
            end
`endif
            ST_TERM: begin
                w_txd_nxt   = TERM_WORD;
                w_done_nxt  = 1'b1;
                w_ifg_nxt   = '0;
                w_state_nxt = ST_IFG;
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_ifg_nxt   = '0;
                    w_state_nxt = ST_IFG;
                end
            end
            ST_IFG: begin
                // tvalid is ignored here so the gap is never shortened.
                w_ifg_nxt = r_ifg_cnt + 1'b1;
                if (r_ifg_cnt >= IFG_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ifg_cnt <= '0;
            r_txd     <= IDLE_WORD;
            r_txc     <= 4'hF;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef MAC_TX_FCS_EN
            r_crc     <= 32'hFFFFFFFF;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ifg_cnt <= w_ifg_nxt;
            r_txd     <= w_txd_nxt;
            r_txc     <= w_txc_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
`ifdef MAC_TX_FCS_EN
            r_crc     <= w_crc_nxt;
`endif
        end
    end

    assign xgmii_txd     = r_txd;
    assign xgmii_txc     = r_txc;
    assign tx_frame_done = r_done;
    assign tx_err        = r_err;

endmodule

// File: tb/tb_mac_tx_framer.sv
module tb_mac_tx_framer;

    localparam int IFG_WORDS = 3;
    localparam int MIN_WORDS = 15;

    localparam logic [31:0] IDLE_W  = 32'h07070707;
    localparam logic [31:0] START_W = 32'h555555FB;
    localparam logic [31:0] PRE_W   = 32'hD5555555;
    localparam logic [31:0] TERM_W  = 32'h070707FD;
    localparam logic [31:0] ERR_W   = 32'hFEFEFEFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = 4'hF;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_trdy;
    logic [31:0] xgmii_txd;
    logic [3:0]  xgmii_txc;
    logic        tx_frame_done;
    logic        tx_err;

    always #5 clk = ~clk;

    mac_tx_framer #(.IFG_WORDS(IFG_WORDS), .MIN_WORDS(MIN_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_trdy  (s_axis_trdy),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .tx_frame_done(tx_frame_done),
        .tx_err       (tx_err)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  c;
        logic        done;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int gap_cnt = 0;
    int last_gap = -1;
    int gaps_seen = 0;
    bit in_gap = 1'b0;

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] c,
                                input logic dn, input logic er);
        exp_t x;
        x.d = d; x.c = c; x.done = dn; x.err = er;
        return x;
    endfunction

    // Payload word i of a frame whose first byte is 'base'; lane 0 first.
    function automatic logic [31:0] pay(input int base, input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(base + 4*i + j);
        return w;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] fcs_of(input int n, input int base);
        logic [31:0] c;
        logic [31:0] w;
        int total;
        c = 32'hFFFFFFFF;
        total = (n < MIN_WORDS) ? MIN_WORDS : n;
        for (int i = 0; i < total; i++) begin
            w = (i < n) ? pay(base, i) : 32'h0;
            for (int j = 0; j < 4; j++) c = crc_byte(c, w[8*j +: 8]);
        end
        return ~c;
    endfunction

    task automatic push_good(input int n, input int base);
        q.push_back(mk(START_W, 4'b0001, 1'b0, 1'b0));
        q.push_back(mk(PRE_W, 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < n; i++) q.push_back(mk(pay(base, i), 4'h0, 1'b0, 1'b0));
        for (int i = n; i < MIN_WORDS; i++) q.push_back(mk(32'h0, 4'h0, 1'b0, 1'b0));
`ifdef MAC_TX_FCS_EN
        q.push_back(mk(fcs_of(n, base), 4'h0, 1'b0, 1'b0));
`endif
        q.push_back(mk(TERM_W, 4'hF, 1'b1, 1'b0));
    endtask

    // Scoreboard: every non-idle word must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_frame_done) done_cnt++;
            if (tx_err) err_cnt++;
            if (xgmii_txc == 4'hF && xgmii_txd == IDLE_W) begin
                if (in_gap) gap_cnt++;
                if (tx_frame_done || tx_err) begin
                    vectors++; miscompares++;
                    $display("FAIL idle_pulse: done=%0b err=%0b on idle word, required 0 0",
                             tx_frame_done, tx_err);
                end
            end else begin
                if (xgmii_txc == 4'hF && xgmii_txd == TERM_W) begin
                    in_gap = 1'b1; gap_cnt = 0;
                end else if (xgmii_txc == 4'b0001 && xgmii_txd == START_W && in_gap) begin
                    last_gap = gap_cnt; gaps_seen++; in_gap = 1'b0;
                end
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got %h/%h done=%0b err=%0b, required no word",
                             xgmii_txd, xgmii_txc, tx_frame_done, tx_err);
                end else begin
                    e = q.pop_front();
                    if ({xgmii_txd, xgmii_txc, tx_frame_done, tx_err} !== {e.d, e.c, e.done, e.err}) begin
                        miscompares++;
                        $display("FAIL word: got %h/%h done=%0b err=%0b, required %h/%h done=%0b err=%0b",
                                 xgmii_txd, xgmii_txc, tx_frame_done, tx_err, e.d, e.c, e.done, e.err);
                    end
                end
            end
        end
    end

    // Offer one word until accepted; returns the number of cycles it took.
    task automatic drive_word(input logic [31:0] d, input logic [3:0] k,
                              input logic last, output int waited);
        logic rdy;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        waited = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            rdy = s_axis_trdy;
            @(posedge clk);
            #1;
            if (rdy) begin
                waited = c;
                break;
            end
        end
        if (waited < 0) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: word %h not accepted in 60 cycles, required acceptance", d);
        end
    endtask

    task automatic send_frame(input int n, input int base, input bit hold);
        int w;
        push_good(n, base);
        for (int i = 0; i < n; i++) drive_word(pay(base, i), 4'hF, (i == n - 1), w);
        if (!hold) begin
            s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (xgmii_txd !== IDLE_W) begin miscompares++; $display("FAIL rst_txd: got %h, required %h", xgmii_txd, IDLE_W); end
        vectors++; if (xgmii_txc !== 4'hF) begin miscompares++; $display("FAIL rst_txc: got %h, required f", xgmii_txc); end
        vectors++; if (s_axis_trdy !== 1'b0) begin miscompares++; $display("FAIL rst_trdy: got %b, required 0", s_axis_trdy); end
        vectors++; if (tx_frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, required 0", tx_frame_done); end
        vectors++; if (tx_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", tx_err); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_frame(input int n, input int base);
        int d0;
        d0 = done_cnt;
        send_frame(n, base, 1'b0);
        wait_drain();
        vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL frame%0d_drain: %0d words left, required 0", n, q.size()); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL frame%0d_done: got %0d pulses, required 1", n, done_cnt - d0); end
    endtask

    task automatic test_underrun();
        int w, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        q.push_back(mk(START_W, 4'b0001, 1'b0, 1'b0));
        q.push_back(mk(PRE_W, 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) q.push_back(mk(pay(32, i), 4'h0, 1'b0, 1'b0));
        q.push_back(mk(ERR_W, 4'hF, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++) drive_word(pay(32, i), 4'hF, 1'b0, w);
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 5; i < 10; i++) begin
            drive_word(pay(32, i), 4'hF, (i == 9), w);
            vectors++; if (w !== 1) begin miscompares++; $display("FAIL drop_trdy: word %0d took %0d cycles, required 1", i, w); end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        wait_drain();
        vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL underrun_drain: %0d left, required 0", q.size()); end
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL underrun_err: got %0d, required 1", err_cnt - e0); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL underrun_done: got %0d, required 0", done_cnt - d0); end
    endtask

    task automatic test_bad_keep(input bit on_last);
        int w, e0, d0, n, bad;
        n = on_last ? 4 : 6;
        bad = on_last ? 3 : 2;
        e0 = err_cnt; d0 = done_cnt;
        q.push_back(mk(START_W, 4'b0001, 1'b0, 1'b0));
        q.push_back(mk(PRE_W, 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < bad; i++) q.push_back(mk(pay(48, i), 4'h0, 1'b0, 1'b0));
        q.push_back(mk(ERR_W, 4'hF, 1'b0, 1'b1));
        for (int i = 0; i < n; i++) begin
            drive_word(pay(48, i), (i == bad) ? 4'h7 : 4'hF, (i == n - 1), w);
            if (i == bad) begin
                vectors++;
                if (s_axis_trdy !== !on_last) begin
                    miscompares++;
                    $display("FAIL keep_state_trdy: last=%0b got %b, required %b", on_last, s_axis_trdy, !on_last);
                end
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        wait_drain();
        vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL keep_drain: %0d left, required 0", q.size()); end
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL keep_err: got %0d, required 1", err_cnt - e0); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL keep_done: got %0d, required 0", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int g0;
        in_gap = 1'b0;
        g0 = gaps_seen;
        send_frame(16, 5, 1'b1);
        send_frame(4, 77, 1'b0);
        wait_drain();
        vectors++; if (gaps_seen - g0 !== 1) begin miscompares++; $display("FAIL b2b_gap_seen: got %0d, required 1", gaps_seen - g0); end
        vectors++; if (last_gap !== IFG_WORDS) begin miscompares++; $display("FAIL b2b_gap: got %0d idle words, required %0d", last_gap, IFG_WORDS); end
        vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL b2b_drain: %0d left, required 0", q.size()); end
    endtask

    task automatic test_reset_midframe();
        int w, d0, e0;
        q.delete();
        q.push_back(mk(START_W, 4'b0001, 1'b0, 1'b0));
        q.push_back(mk(PRE_W, 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) q.push_back(mk(pay(128, i), 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            drive_word(pay(128, i), 4'hF, 1'b0, w);
            vectors++;
            if ({xgmii_txd, xgmii_txc} !== {pay(128, i), 4'h0}) begin
                miscompares++;
                $display("FAIL latency: got %h/%h, required %h/0", xgmii_txd, xgmii_txc, pay(128, i));
            end
        end
        s_axis_tdata = pay(128, 3);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        vectors++; if (xgmii_txd !== IDLE_W) begin miscompares++; $display("FAIL mid_rst_txd: got %h, required %h", xgmii_txd, IDLE_W); end
        vectors++; if (xgmii_txc !== 4'hF) begin miscompares++; $display("FAIL mid_rst_txc: got %h, required f", xgmii_txc); end
        vectors++; if (s_axis_trdy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_trdy: got %b, required 0", s_axis_trdy); end
        vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL mid_rst_q: %0d left, required 0", q.size()); end
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (8) @(posedge clk);
        #1;
        vectors++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin miscompares++; $display("FAIL mid_rst_tail: got %0d pulses, required 0", (done_cnt - d0) + (err_cnt - e0)); end
        test_frame(5, 144);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame(16, 0);
        test_frame(4, 64);
        test_frame(15, 100);
        test_frame(14, 200);
        test_underrun();
        test_bad_keep(1'b0);
        test_bad_keep(1'b1);
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
